// File: rtl/hmmm_fetch.sv
`default_nettype none
// ============================================================================
// Module   : hmmm_fetch
// Brief    : Instruction-fetch sequencer for the Hmmm core (PC -> RAM -> IR).
// Revision : 1.0 - initial release
// ============================================================================
module hmmm_fetch #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] bus_in,
    input  logic              ram_ready,
    input  logic              ir_ack,
    input  logic              halt,
    output logic              pc_out,
    output logic              pc_increment,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_rd,
    output logic [DATA_W-1:0] ir,
    output logic              ir_valid,
    output logic              fault,
    output logic [15:0]       fetch_count,
    output logic              halted
);

    localparam logic [2:0] c_idle   = 3'd0;
    localparam logic [2:0] c_addr   = 3'd1;
    localparam logic [2:0] c_read   = 3'd2;
    localparam logic [2:0] c_hold   = 3'd3;
    localparam logic [2:0] c_halted = 3'd4;
    localparam logic [2:0] c_fault  = 3'd5;

    // The TIMEOUT-th ready-less READ cycle is the one that faults.
    localparam logic [7:0] c_wait_last = 8'(TIMEOUT - 1);

    logic [2:0]        r_state;
    logic [2:0]        w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_ir;
    logic [7:0]        r_wait;
    logic [15:0]       r_count;
    logic              w_accept;

    assign w_accept = (r_state == c_read) && ram_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_idle:   w_next = halt ? c_halted : c_addr;
            c_addr:   w_next = c_read;
            c_read: begin
                if (ram_ready) begin
                    w_next = c_hold;
                end else if (r_wait == c_wait_last) begin
                    w_next = c_fault;
                end
            end
            c_hold: begin
                if (ir_ack) begin
                    w_next = halt ? c_halted : c_addr;
                end
            end
            c_halted: w_next = halt ? c_halted : c_addr;
            c_fault:  w_next = c_fault;
            default:  w_next = c_idle;
        endcase
    end

    always_comb begin
        pc_out       = (r_state == c_addr);
        ram_rd       = (r_state == c_read);
        ir_valid     = (r_state == c_hold);
        halted       = (r_state == c_halted);
        fault        = (r_state == c_fault);
        // Mealy strobe so pc advances in the same cycle the word is taken.
        pc_increment = w_accept;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr  <= '0;
            r_ir    <= '0;
            r_wait  <= '0;
            r_count <= '0;
        end else begin
            if (r_state == c_addr) begin
                r_addr <= bus_in[ADDR_W-1:0];
                r_wait <= '0;
            end
            if (w_accept) begin
                r_ir    <= bus_in;
                r_count <= r_count + 16'd1;
            end else if (r_state == c_read) begin
                r_wait <= r_wait + 8'd1;
            end
        end
    end

    assign ram_addr    = r_addr;
    assign ir          = r_ir;
    assign fetch_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_hmmm_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_hmmm_fetch
// Brief    : Self-checking bench for hmmm_fetch; the bench plays pc and RAM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hmmm_fetch;

    logic        clk;
    logic        rst;
    logic [15:0] bus_in;
    logic        ram_ready;
    logic        ir_ack;
    logic        halt;
    logic        pc_out;
    logic        pc_increment;
    logic [7:0]  ram_addr;
    logic        ram_rd;
    logic [15:0] ir;
    logic        ir_valid;
    logic        fault;
    logic [15:0] fetch_count;
    logic        halted;

    hmmm_fetch #(.ADDR_W(8), .DATA_W(16), .TIMEOUT(15)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus_in       (bus_in),
        .ram_ready    (ram_ready),
        .ir_ack       (ir_ack),
        .halt         (halt),
        .pc_out       (pc_out),
        .pc_increment (pc_increment),
        .ram_addr     (ram_addr),
        .ram_rd       (ram_rd),
        .ir           (ir),
        .ir_valid     (ir_valid),
        .fault        (fault),
        .fetch_count  (fetch_count),
        .halted       (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_chk;
    int          n_err;
    int          cyc;
    int          inc_count;
    int          both_hi;
    int          exp_inc;
    logic [15:0] exp_fc;

    typedef struct {
        logic [15:0] pcv;
        int          waits;
        logic [15:0] data;
        int          ack_delay;
        logic [7:0]  exp_addr;
        logic [15:0] exp_ir;
    } vec_t;

    vec_t        vecs[5];
    logic [15:0] mem[256];
    logic [15:0] pc_m;
    logic [15:0] ir_before;
    int          c0;

    always @(negedge clk) begin
        if (pc_increment) inc_count++;
        if (pc_out && ram_rd) both_hi++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Precondition: DUT is in ADDR (sampled just after an edge).
    task automatic run_fetch(input logic [15:0] pcv, input int waits, input logic [15:0] data,
                             input int ack_delay, input bit hlt,
                             input logic [7:0] exp_addr, input logic [15:0] exp_ir);
        chk("addr_pc_out", pc_out, 1);
        chk("addr_ram_rd", ram_rd, 0);
        chk("addr_ir_valid", ir_valid, 0);
        bus_in = pcv;
        step();
        for (int w = 0; w <= waits; w++) begin
            chk("read_ram_rd", ram_rd, 1);
            chk("read_pc_out", pc_out, 0);
            chk("read_ram_addr", ram_addr, exp_addr);
            chk("read_ir_valid", ir_valid, 0);
            ram_ready = (w == waits);
            bus_in    = (w == waits) ? data : 16'($urandom);
            if (hlt) halt = 1'b1;
            #1;
            chk("read_pc_increment", pc_increment, (w == waits));
            step();
        end
        ram_ready = 1'b0;
        exp_fc++;
        exp_inc++;
        chk("hold_ir_valid", ir_valid, 1);
        chk("hold_ir", ir, exp_ir);
        chk("hold_fetch_count", fetch_count, exp_fc);
        chk("hold_inc_pulses", inc_count, exp_inc);
        for (int d = 0; d < ack_delay; d++) begin
            ir_ack    = 1'b0;
            bus_in    = 16'($urandom);
            ram_ready = 1'($urandom);
            step();
            chk("hold_wait_valid", ir_valid, 1);
            chk("hold_wait_ir", ir, exp_ir);
        end
        ram_ready = 1'b0;
        ir_ack    = 1'b1;
        step();
        if (hlt) begin
            chk("halt_halted", halted, 1);
            chk("halt_pc_out", pc_out, 0);
            chk("halt_ir_valid", ir_valid, 0);
            chk("halt_ir_kept", ir, exp_ir);
            ir_ack = 1'b0;
            step();
            chk("halt_stays", halted, 1);
            chk("halt_no_pc_out", pc_out, 0);
            halt = 1'b0;
            step();
            chk("unhalt_halted", halted, 0);
            chk("unhalt_addr", pc_out, 1);
        end
    endtask

    initial begin
        n_chk = 0; n_err = 0; cyc = 0; inc_count = 0; both_hi = 0;
        exp_inc = 0; exp_fc = 16'd0;
        rst = 1'b1; bus_in = 16'hFFFF; ram_ready = 1'b1; ir_ack = 1'b1; halt = 1'b0;

        vecs[0] = '{16'h002A,  0, 16'h1234, 1, 8'h2A, 16'h1234};
        vecs[1] = '{16'h0010,  3, 16'hBEEF, 0, 8'h10, 16'hBEEF};
        vecs[2] = '{16'h00FF,  0, 16'h5A5A, 2, 8'hFF, 16'h5A5A};
        vecs[3] = '{16'hAB77, 14, 16'hC0DE, 0, 8'h77, 16'hC0DE};
        vecs[4] = '{16'h1280,  1, 16'h0000, 1, 8'h80, 16'h0000};

        // Reset state
        step();
        step();
        chk("reset_outputs", {pc_out, pc_increment, ram_addr, ram_rd, ir, ir_valid,
                              fault, fetch_count, halted}, 64'd0);
        ram_ready = 1'b0; ir_ack = 1'b0; bus_in = 16'h0;
        rst = 1'b0;
        #1;
        chk("idle_pc_out", pc_out, 0);
        step();

        foreach (vecs[i])
            run_fetch(vecs[i].pcv, vecs[i].waits, vecs[i].data, vecs[i].ack_delay, 1'b0,
                      vecs[i].exp_addr, vecs[i].exp_ir);

        // Back-to-back with ir_ack tied high: one fetch per 3 cycles
        ir_ack = 1'b1;
        c0 = cyc;
        for (int i = 0; i < 4; i++)
            run_fetch(16'(i), 0, 16'hA000 + 16'(i), 0, 1'b0, 8'(i), 16'hA000 + 16'(i));
        chk("b2b_cycles", cyc - c0, 12);
        chk("b2b_fetch_count", fetch_count, exp_fc);
        ir_ack = 1'b0;

        // halt during READ: completes, holds, then halts
        run_fetch(16'h0033, 2, 16'h7777, 1, 1'b1, 8'h33, 16'h7777);

        // RAM never answers
        ir_before = ir;
        chk("to_addr", pc_out, 1);
        bus_in = 16'h0099;
        step();
        for (int i = 0; i < 15; i++) begin
            chk("to_read_rd", ram_rd, 1);
            chk("to_no_fault_yet", fault, 0);
            bus_in = 16'($urandom);
            step();
        end
        chk("to_fault", fault, 1);
        chk("to_ram_rd", ram_rd, 0);
        chk("to_pc_out", pc_out, 0);
        chk("to_ir_kept", ir, ir_before);
        for (int i = 0; i < 4; i++) begin
            ram_ready = 1'($urandom); ir_ack = 1'($urandom); bus_in = 16'($urandom);
            #1;
            chk("to_fault_inc", pc_increment, 0);
            step();
            chk("to_fault_sticky", fault, 1);
        end
        ram_ready = 1'b0; ir_ack = 1'b0;
        chk("to_no_pulses", inc_count, exp_inc);

        // Asynchronous reset out of FAULT, then mid-READ, then mid-HOLD
        rst = 1'b1;
        #1;
        chk("rst_fault_clr", fault, 0);
        chk("rst_count_clr", fetch_count, 0);
        chk("rst_ir_clr", ir, 0);
        exp_fc = 16'd0;
        step();
        rst = 1'b0;
        chk("rst1_idle", pc_out, 0);
        step();
        chk("rst1_addr", pc_out, 1);
        ir_ack = 1'b1;
        bus_in = 16'h0042;
        step();
        ir_ack = 1'b0;
        chk("ack_ignored_read", ram_rd, 1);
        chk("ack_ignored_addr", ram_addr, 8'h42);
        rst = 1'b1;
        ram_ready = 1'b1;
        bus_in = 16'h9999;
        #1;
        chk("rst_read_ram_rd", ram_rd, 0);
        chk("rst_read_inc", pc_increment, 0);
        chk("rst_read_addr", ram_addr, 0);
        ram_ready = 1'b0;
        step();
        rst = 1'b0;
        chk("rst2_idle", pc_out, 0);
        step();
        chk("rst2_addr", pc_out, 1);
        bus_in = 16'h0042;
        step();
        ram_ready = 1'b1;
        bus_in = 16'h9999;
        step();
        ram_ready = 1'b0;
        exp_inc++;
        chk("pre_rst_hold_valid", ir_valid, 1);
        chk("pre_rst_hold_count", fetch_count, 1);
        rst = 1'b1;
        #1;
        chk("rst_hold_valid", ir_valid, 0);
        chk("rst_hold_count", fetch_count, 0);
        chk("rst_hold_ir", ir, 0);
        step();
        rst = 1'b0;
        chk("rst3_idle", pc_out, 0);
        step();

        // Random fetches against the pc/RAM model
        foreach (mem[i]) mem[i] = 16'($urandom);
        pc_m = 16'($urandom);
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) pc_m = 16'($urandom);
            run_fetch(pc_m, $urandom_range(0, 14), mem[pc_m[7:0]], $urandom_range(0, 3),
                      ($urandom_range(0, 4) == 0), pc_m[7:0], mem[pc_m[7:0]]);
            pc_m = pc_m + 16'd1;
        end
        chk("rand_fetch_count", fetch_count, exp_fc);
        chk("total_inc_pulses", inc_count, exp_inc);
        chk("pc_out_ram_rd_exclusive", both_hi, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
